ship_placer: RTL and testbench

Setup-phase controller that turns player-board clicks into a validated fleet layout. It sits directly downstream of the mouse controller: it consumes the registered `player_cor` coordinate (`8'hff` = no click, otherwise `{x[3:0], y[3:0]}`) and places the fleet one ship at a time, bow click then stern click. It keeps a per-cell occupancy bitmap that the player-board renderer and the game FSM read through a registered read port.

---
 rtl/project_cfg_pkg.sv | 36 +++
 rtl/ship_placer_click_det.sv | 36 +++
 rtl/ship_placer.sv | 210 +++++++++++++++++++++
 tb/tb_ship_placer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_cfg_pkg.sv
`default_nettype none
// ============================================================================
// project_cfg_pkg : board/fleet constants and the setup-phase FSM state type
// Rev 1.0
// ============================================================================
package project_cfg_pkg;

    localparam int         GRID_N     = 10;
    localparam int         FLEET_SIZE = 10;
    localparam logic [7:0] NO_COR     = 8'hff;

    localparam logic [2:0] SHIP_LEN [0:9] = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd2,
                                             3'd2, 3'd1, 3'd1, 3'd1, 3'd1};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLEAR      = 3'd1,
        S_WAIT_BOW   = 3'd2,
        S_WAIT_STERN = 3'd3,
        S_CHECK      = 3'd4,
        S_WRITE      = 3'd5,
        S_DONE       = 3'd6
    } placer_state_t;

    // Past the end of the fleet (ship_idx == FLEET_SIZE) there is no ship.
    function automatic logic [2:0] ship_len_of(input logic [3:0] idx);
        logic [2:0] len;
        len = 3'd0;
        if (idx < 4'd10) begin
            len = SHIP_LEN[idx];
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ship_placer_click_det.sv
`default_nettype none
// ============================================================================
// cor_click_det : turns a level coordinate stream into one-shot click events
// Rev 1.0
// ============================================================================
module cor_click_det #(
    parameter int GRID_N = project_cfg_pkg::GRID_N
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_cor,
    output logic       click,
    output logic [7:0] click_cor,
    output logic       in_grid
);
    import project_cfg_pkg::NO_COR;

    localparam logic [4:0] c_grid_n = 5'(GRID_N);

    logic [7:0] r_cor_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cor_q <= NO_COR;
        end else begin
            r_cor_q <= i_cor;
        end
    end

    // Only the first cycle of a held button counts.
    assign click     = (i_cor != NO_COR) && (r_cor_q == NO_COR);
    assign click_cor = i_cor;
    assign in_grid   = ({1'b0, i_cor[7:4]} < c_grid_n) && ({1'b0, i_cor[3:0]} < c_grid_n);

endmodule
`default_nettype wire

// File: rtl/ship_placer.sv
`default_nettype none
// ============================================================================
// ship_placer : setup-phase controller, bow/stern clicks -> occupancy bitmap
// Rev 1.0
// ============================================================================
module ship_placer #(
    parameter int GRID_N     = project_cfg_pkg::GRID_N,
    parameter int FLEET_SIZE = project_cfg_pkg::FLEET_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       place_en,
    input  logic [7:0] player_cor,
    input  logic [7:0] rd_cor,
    output logic       rd_occ,
    output logic [3:0] ship_idx,
    output logic [2:0] ship_len,
    output logic       bow_valid,
    output logic [7:0] bow_cor,
    output logic       placed,
    output logic       err,
    output logic       done
);
    import project_cfg_pkg::*;

    localparam int                CELLS       = GRID_N * GRID_N;
    localparam int                IDX_W       = $clog2(CELLS);
    localparam logic [IDX_W-1:0]  c_grid_idx  = IDX_W'(GRID_N);
    localparam logic [4:0]        c_grid_n    = 5'(GRID_N);
    localparam logic [3:0]        c_last_ship = 4'(FLEET_SIZE - 1);

    placer_state_t    r_state;
    placer_state_t    w_next;
    logic [CELLS-1:0] r_bitmap;
    logic [3:0]       r_ship_idx;
    logic [7:0]       r_bow;
    logic [3:0]       r_lo_x;
    logic [3:0]       r_lo_y;
    logic             r_horiz;
    logic [3:0]       r_cnt;
    logic             r_hit;
    logic             r_placed;
    logic             r_err;
    logic             r_rd_occ;

    logic             w_click;
    logic [7:0]       w_click_cor;
    logic             w_in_grid;
    logic             w_ev;
    logic             w_abort;
    logic [3:0]       w_len4;
    logic [3:0]       w_bx, w_by, w_sx, w_sy;
    logic [3:0]       w_dx, w_dy, w_span;
    logic             w_same_x, w_same_y, w_geom_ok;
    logic             w_last;
    logic [3:0]       w_cell_x, w_cell_y;
    logic [IDX_W-1:0] w_cell_idx;
    logic             w_cell_occ;
    logic             w_rd_in;
    logic [IDX_W-1:0] w_rd_idx;

    cor_click_det #(
        .GRID_N (GRID_N)
    ) u_click_det (
        .clk       (clk),
        .rst       (rst),
        .i_cor     (player_cor),
        .click     (w_click),
        .click_cor (w_click_cor),
        .in_grid   (w_in_grid)
    );

    assign w_ev    = w_click && w_in_grid;
    assign w_abort = !place_en && (r_state != S_IDLE);
    assign w_len4  = {1'b0, ship_len_of(r_ship_idx)};

    // Stern geometry against the held bow
    assign w_bx      = r_bow[7:4];
    assign w_by      = r_bow[3:0];
    assign w_sx      = w_click_cor[7:4];
    assign w_sy      = w_click_cor[3:0];
    assign w_same_x  = (w_bx == w_sx);
    assign w_same_y  = (w_by == w_sy);
    assign w_dx      = (w_bx >= w_sx) ? (w_bx - w_sx) : (w_sx - w_bx);
    assign w_dy      = (w_by >= w_sy) ? (w_by - w_sy) : (w_sy - w_by);
    assign w_span    = w_same_y ? (w_dx + 4'd1) : (w_dy + 4'd1);
    assign w_geom_ok = (w_same_x || w_same_y) && (w_span == w_len4)
                       && ((w_len4 != 4'd1) || (w_click_cor == r_bow));

    // Cell walked by CHECK and WRITE
    assign w_last     = (r_cnt == (w_len4 - 4'd1));
    assign w_cell_x   = r_lo_x + (r_horiz ? r_cnt : 4'd0);
    assign w_cell_y   = r_lo_y + (r_horiz ? 4'd0 : r_cnt);
    assign w_cell_idx = IDX_W'(w_cell_y) * c_grid_idx + IDX_W'(w_cell_x);
    assign w_cell_occ = r_bitmap[w_cell_idx];

    assign w_rd_in  = ({1'b0, rd_cor[7:4]} < c_grid_n) && ({1'b0, rd_cor[3:0]} < c_grid_n);
    assign w_rd_idx = IDX_W'(rd_cor[3:0]) * c_grid_idx + IDX_W'(rd_cor[7:4]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:       if (place_en) w_next = S_CLEAR;
                S_CLEAR:      w_next = S_WAIT_BOW;
                S_WAIT_BOW:   if (w_ev) w_next = S_WAIT_STERN;
                S_WAIT_STERN: if (w_ev) w_next = w_geom_ok ? S_CHECK : S_WAIT_BOW;
                S_CHECK:      if (w_last) w_next = (r_hit || w_cell_occ) ? S_WAIT_BOW : S_WRITE;
                S_WRITE:      if (w_last) w_next = (r_ship_idx == c_last_ship) ? S_DONE : S_WAIT_BOW;
                S_DONE:       w_next = S_DONE;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitmap   <= '0;
            r_ship_idx <= 4'd0;
            r_bow      <= NO_COR;
            r_lo_x     <= 4'd0;
            r_lo_y     <= 4'd0;
            r_horiz    <= 1'b0;
            r_cnt      <= 4'd0;
            r_hit      <= 1'b0;
            r_placed   <= 1'b0;
            r_err      <= 1'b0;
            r_rd_occ   <= 1'b0;
        end else begin
            r_placed <= 1'b0;
            r_err    <= 1'b0;
            r_rd_occ <= w_rd_in && r_bitmap[w_rd_idx];
            if (w_abort) begin
                r_bow <= NO_COR;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        r_bitmap   <= '0;
                        r_ship_idx <= 4'd0;
                        r_bow      <= NO_COR;
                    end
                    S_WAIT_BOW: begin
                        if (w_ev) r_bow <= w_click_cor;
                    end
                    S_WAIT_STERN: begin
                        if (w_ev) begin
                            if (w_geom_ok) begin
                                r_horiz <= w_same_y;
                                r_lo_x  <= (w_same_y && (w_sx < w_bx)) ? w_sx : w_bx;
                                r_lo_y  <= (!w_same_y && (w_sy < w_by)) ? w_sy : w_by;
                                r_cnt   <= 4'd0;
                                r_hit   <= 1'b0;
                            end else begin
                                r_err <= 1'b1;
                                r_bow <= NO_COR;
                            end
                        end
                    end
                    S_CHECK: begin
                        // Walk the whole span so rejection timing is length-fixed
                        if (w_cell_occ) r_hit <= 1'b1;
                        if (w_last) begin
                            r_cnt <= 4'd0;
                            if (r_hit || w_cell_occ) begin
                                r_err <= 1'b1;
                                r_bow <= NO_COR;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_WRITE: begin
                        r_bitmap[w_cell_idx] <= 1'b1;
                        if (w_last) begin
                            r_placed   <= 1'b1;
                            r_ship_idx <= r_ship_idx + 4'd1;
                            r_bow      <= NO_COR;
                            r_cnt      <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rd_occ    = r_rd_occ;
    assign ship_idx  = r_ship_idx;
    assign ship_len  = (r_state == S_DONE) ? 3'd0 : w_len4[2:0];
    assign bow_valid = (r_state == S_WAIT_STERN);
    assign bow_cor   = r_bow;
    assign placed    = r_placed;
    assign err       = r_err;
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ship_placer.sv
`default_nettype none
// ============================================================================
// tb_ship_placer : directed scoreboard bench for ship_placer
// Rev 1.0
// ============================================================================
module tb_ship_placer;

    logic       clk = 1'b0;
    logic       rst;
    logic       place_en;
    logic [7:0] player_cor;
    logic [7:0] rd_cor;
    logic       rd_occ;
    logic [3:0] ship_idx;
    logic [2:0] ship_len;
    logic       bow_valid;
    logic [7:0] bow_cor;
    logic       placed;
    logic       err;
    logic       done;

    ship_placer dut (
        .clk        (clk),
        .rst        (rst),
        .place_en   (place_en),
        .player_cor (player_cor),
        .rd_cor     (rd_cor),
        .rd_occ     (rd_occ),
        .ship_idx   (ship_idx),
        .ship_len   (ship_len),
        .bow_valid  (bow_valid),
        .bow_cor    (bow_cor),
        .placed     (placed),
        .err        (err),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int         lens  [10] = '{4, 3, 3, 2, 2, 2, 1, 1, 1, 1};
    logic [7:0] bows  [10] = '{8'h00, 8'h55, 8'h90, 8'h14, 8'h06, 8'h08, 8'h99, 8'h97, 8'h95, 8'h93};
    logic [7:0] sterns[10] = '{8'h30, 8'h75, 8'h92, 8'h04, 8'h16, 8'h18, 8'h99, 8'h97, 8'h95, 8'h93};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_cmp(obs);
    endtask

    task automatic press(input logic [7:0] cor);
        player_cor = cor;
        tick();
        player_cor = 8'hff;
    endtask

    task automatic read_chk(input logic [7:0] cor, input logic exp, input string tag);
        rd_cor = cor;
        tick();
        chk(tag, rd_occ, exp);
    endtask

    // Stern click then wait for the commit pulse at cycle E0 + 2*len + 1
    task automatic stern_wait(input logic [7:0] stern, input int len, input int k);
        press(stern);
        push("placed_early", 0);
        push("placed", 1);
        push("ship_idx_inc", k + 1);
        repeat (2 * len - 1) tick();
        pop_cmp(placed);
        tick();
        pop_cmp(placed);
        pop_cmp(ship_idx);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_err_held;

        rst        = 1'b1;
        place_en   = 1'b0;
        player_cor = 8'hff;
        rd_cor     = 8'hff;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ship_idx",  ship_idx,  0);
        chk("rst_ship_len",  ship_len,  4);
        chk("rst_bow_cor",   bow_cor,   8'hff);
        chk("rst_bow_valid", bow_valid, 0);
        chk("rst_placed",    placed,    0);
        chk("rst_err",       err,       0);
        chk("rst_done",      done,      0);
        chk("rst_rd_occ",    rd_occ,    0);

        place_en = 1'b1;
        tick();
        tick();
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                read_chk({4'(x), 4'(y)}, 1'b0, "cell_init");
            end
        end
        chk("init_ship_idx", ship_idx, 0);
        chk("init_ship_len", ship_len, 4);

        // Ship 0: horizontal (0..3,0)
        press(bows[0]);
        chk("s0_bow_valid", bow_valid, 1);
        chk("s0_bow_cor",   bow_cor,   8'h00);
        tick();
        stern_wait(sterns[0], 4, 0);
        for (int x = 0; x < 4; x++) begin
            read_chk({4'(x), 4'd0}, 1'b1, "s0_cell");
        end
        read_chk(8'h40, 1'b0, "s0_after_end");
        read_chk(8'h01, 1'b0, "s0_next_row");
        chk("s1_ship_len", ship_len, 3);

        // Diagonal stern -> immediate reject
        press(8'h22);
        tick();
        press(8'h33);
        chk("diag_err",       err,       1);
        chk("diag_bow_valid", bow_valid, 0);
        chk("diag_bow_cor",   bow_cor,   8'hff);
        tick();
        chk("diag_err_pulse", err, 0);
        read_chk(8'h22, 1'b0, "diag_cell_a");
        read_chk(8'h33, 1'b0, "diag_cell_b");

        // Overlap with (1,0) -> reject after CHECK
        press(8'h10);
        tick();
        press(8'h12);
        chk("ovl_err_early1", err, 0);
        tick();
        tick();
        chk("ovl_err_early3", err, 0);
        tick();
        chk("ovl_err",      err,      1);
        chk("ovl_ship_idx", ship_idx, 1);
        chk("ovl_bow_cor",  bow_cor,  8'hff);
        tick();
        chk("ovl_err_pulse", err, 0);
        read_chk(8'h11, 1'b0, "ovl_cell_1");
        read_chk(8'h12, 1'b0, "ovl_cell_2");
        read_chk(8'h10, 1'b1, "ovl_cell_0");

        // Held button: exactly one event
        n_err_held = 0;
        player_cor = 8'h55;
        repeat (50) begin
            tick();
            if (err) n_err_held++;
        end
        chk("held_err_cnt",   n_err_held, 0);
        chk("held_bow_valid", bow_valid,  1);
        chk("held_bow_cor",   bow_cor,    8'h55);
        player_cor = 8'hff;
        tick();
        press(8'hA0);
        chk("oob_err",       err,       0);
        chk("oob_bow_valid", bow_valid, 1);
        chk("oob_bow_cor",   bow_cor,   8'h55);
        tick();
        stern_wait(sterns[1], 3, 1);
        read_chk(8'h55, 1'b1, "s1_cell_5");
        read_chk(8'h65, 1'b1, "s1_cell_6");
        read_chk(8'h75, 1'b1, "s1_cell_7");
        read_chk(8'hF4, 1'b0, "rd_oob_x_nowrap");
        read_chk(8'h5A, 1'b0, "rd_oob_y");
        read_chk(8'hff, 1'b0, "rd_no_cor");

        // Rest of the fleet
        for (int k = 2; k < 10; k++) begin
            chk("fleet_ship_len", ship_len, lens[k]);
            press(bows[k]);
            chk("fleet_bow_valid", bow_valid, 1);
            tick();
            stern_wait(sterns[k], lens[k], k);
        end
        chk("done_level",    done,     1);
        chk("done_ship_len", ship_len, 0);
        read_chk(8'h91, 1'b1, "fleet_vert_mid");
        read_chk(8'h04, 1'b1, "fleet_rev_lo");
        read_chk(8'h24, 1'b0, "fleet_rev_past");
        read_chk(8'h99, 1'b1, "fleet_single");
        read_chk(8'h94, 1'b0, "fleet_gap");

        // Clicks after DONE are ignored
        press(8'h44);
        tick();
        press(8'h45);
        chk("post_done_err", err, 0);
        repeat (3) tick();
        chk("post_done_placed",    placed,    0);
        chk("post_done_bow_valid", bow_valid, 0);
        chk("post_done_done",      done,      1);
        chk("post_done_ship_idx",  ship_idx,  10);
        read_chk(8'h44, 1'b0, "post_done_cell");

        // Drop and re-raise place_en
        place_en = 1'b0;
        tick();
        chk("drop_done", done, 0);
        read_chk(8'h00, 1'b1, "drop_bitmap_kept");
        place_en = 1'b1;
        tick();
        tick();
        chk("rearm_ship_idx", ship_idx, 0);
        chk("rearm_ship_len", ship_len, 4);
        read_chk(8'h00, 1'b0, "rearm_cleared_a");
        read_chk(8'h99, 1'b0, "rearm_cleared_b");

        // Drop mid-WRITE of ship 0, and read-port same-edge visibility
        press(8'h05);
        tick();
        press(8'h35);
        rd_cor = 8'h05;
        repeat (5) tick();
        chk("rd_same_edge", rd_occ, 0);
        tick();
        chk("rd_next_cycle", rd_occ, 1);
        place_en = 1'b0;
        tick();
        chk("abort_bow_valid", bow_valid, 0);
        chk("abort_bow_cor",   bow_cor,   8'hff);
        chk("abort_placed",    placed,    0);
        repeat (4) tick();
        chk("abort_ship_idx", ship_idx, 0);
        read_chk(8'h05, 1'b1, "abort_partial_0");
        read_chk(8'h15, 1'b1, "abort_partial_1");
        read_chk(8'h35, 1'b0, "abort_no_more");
        place_en = 1'b1;
        tick();
        tick();
        read_chk(8'h05, 1'b0, "abort_cleared_0");
        read_chk(8'h15, 1'b0, "abort_cleared_1");

        // Reset mid-WRITE
        press(8'h05);
        tick();
        press(8'h35);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_bow_cor",   bow_cor,   8'hff);
        chk("midrst_ship_idx",  ship_idx,  0);
        chk("midrst_bow_valid", bow_valid, 0);
        chk("midrst_placed",    placed,    0);
        chk("midrst_err",       err,       0);
        read_chk(8'h05, 1'b0, "midrst_bitmap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
